cordic_pipe: RTL and testbench

//   Fully pipelined, throughput-1 CORDIC engine. Successor to the iterative

---
 rtl/cordic_pipe.sv | 121 ++++++++++++
 tb/tb_cordic_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined CORDIC, one micro-rotation per stage, rotation or vectoring per sample.
// A single global enable stalls every stage when the output is held by downstream backpressure.
module cordic_lut #(
    parameter int BIT_WIDTH = 16,
    parameter int ITERATIONS = 15,
    localparam int LW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1
) (
    input  logic [LW-1:0]        idx_i,
    output logic [BIT_WIDTH-1:0] atan_o
);
    // atan(2^-i) with pi = 2^15, rescaled to the configured angle width
    localparam int TAB [32] = '{0: 8192, 1: 4836, 2: 2555, 3: 1297, 4: 651, 5: 326, 6: 163,
                                7: 81, 8: 41, 9: 20, 10: 10, 11: 5, 12: 3, 13: 1, 14: 1,
                                default: 0};
    logic [31:0] a;
    assign a = TAB[5'(idx_i)];
    if (BIT_WIDTH >= 16) begin : g_up
        assign atan_o = BIT_WIDTH'(a << (BIT_WIDTH - 16));
    end else begin : g_dn
        assign atan_o = BIT_WIDTH'(a >> (16 - BIT_WIDTH));
    end
endmodule

module cordic_pipe #(
    parameter int BIT_WIDTH = 16,
    parameter int ITERATIONS = 15,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [BIT_WIDTH-1:0] in_x,
    input  logic [BIT_WIDTH-1:0] in_y,
    input  logic [BIT_WIDTH-1:0] in_angle,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_x,
    output logic [BIT_WIDTH-1:0] out_y,
    output logic [BIT_WIDTH-1:0] out_angle,
    output logic [TAG_WIDTH-1:0] out_tag
);
    localparam int W = BIT_WIDTH;
    localparam int XW = W + 2;
    localparam int ZW = W + 1;
    localparam int L = ITERATIONS - 1;
    localparam int LW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic signed [XW-1:0] SMAX = {3'b000, {(W - 1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = {3'b111, {(W - 1){1'b0}}};

    logic                 en;
    logic [L:0]           v_q, v_d, m_q, m_d;
    logic [TAG_WIDTH-1:0] t_q [ITERATIONS];
    logic [TAG_WIDTH-1:0] t_d [ITERATIONS];
    logic signed [XW-1:0] x_q [ITERATIONS];
    logic signed [XW-1:0] x_d [ITERATIONS];
    logic signed [XW-1:0] y_q [ITERATIONS];
    logic signed [XW-1:0] y_d [ITERATIONS];
    logic signed [ZW-1:0] z_q [ITERATIONS];
    logic signed [ZW-1:0] z_d [ITERATIONS];
    logic [W-1:0]         at_w [ITERATIONS];
    logic signed [XW-1:0] xp, yp;
    logic signed [ZW-1:0] zp;
    logic                 mp, d;

    assign out_valid = v_q[L];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign v_d       = ITERATIONS'({v_q, in_valid});
    assign m_d       = ITERATIONS'({m_q, in_mode});

    for (genvar i = 0; i < ITERATIONS; i++) begin : g_lut
        cordic_lut #(.BIT_WIDTH(W), .ITERATIONS(ITERATIONS)) u_lut (
            .idx_i (LW'(i)),
            .atan_o(at_w[i])
        );
    end

    // d = 1 means rotate by +atan_i: rotation drives z to 0, vectoring drives y to 0
    always_comb begin
        xp = '0;
        yp = '0;
        zp = '0;
        mp = 1'b0;
        d  = 1'b0;
        for (int i = 0; i < ITERATIONS; i++) begin
            xp = (i == 0) ? $signed({{2{in_x[W-1]}}, in_x}) : x_q[i-1];
            yp = (i == 0) ? $signed({{2{in_y[W-1]}}, in_y}) : y_q[i-1];
            zp = (i == 0) ? $signed({in_angle[W-1], in_angle}) : z_q[i-1];
            mp = m_d[i];
            d = mp ? yp[XW-1] : ~zp[ZW-1];
            t_d[i] = (i == 0) ? in_tag : t_q[i-1];
            x_d[i] = d ? xp - (yp >>> i) : xp + (yp >>> i);
            y_d[i] = d ? yp + (xp >>> i) : yp - (xp >>> i);
            z_d[i] = d ? zp - ZW'(at_w[i]) : zp + ZW'(at_w[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) v_q <= '0;
        else if (en) v_q <= v_d;
        if (en) begin
            m_q <= m_d;
            t_q <= t_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    function automatic logic [W-1:0] sat(input logic signed [XW-1:0] v);
        return (v > SMAX) ? SMAX[W-1:0] : (v < SMIN) ? SMIN[W-1:0] : v[W-1:0];
    endfunction

    assign out_x     = out_valid ? sat(x_q[L]) : '0;
    assign out_y     = out_valid ? sat(y_q[L]) : '0;
    assign out_angle = out_valid ? sat($signed({z_q[L][ZW-1], z_q[L]})) : '0;
    assign out_tag   = out_valid ? t_q[L] : '0;
endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: directed and randomized checks of cordic_pipe against a floating-point
// trigonometric reference, with an in-order scoreboard, stall stability and reset flush.
module tb_cordic_pipe;
    localparam int W = 16;
    localparam int N = 15;
    localparam int T = 4;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [W-1:0] in_x, in_y, in_angle, out_x, out_y, out_angle;
    logic [T-1:0] in_tag, out_tag;

    always #5 clk = ~clk;

    cordic_pipe #(.BIT_WIDTH(W), .ITERATIONS(N), .TAG_WIDTH(T)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_angle(in_angle),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_angle(out_angle), .out_tag(out_tag)
    );

    typedef struct {
        int x; int y; int a; int tag; int tol; int atol; int acc; bit lat;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0, cyc = 0, n_out = 0;
    int cur_tol = 16, cur_atol = 16;
    bit cur_lat = 1'b1, acc = 1'b0, held = 1'b0;
    real k_gain = 1.0;
    logic [W-1:0] sx, sy, sa;
    logic [T-1:0] st;
    int md [32], rx [32], ry [32], ra [32];

    function automatic int rnd(input real r);
        return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    endfunction

    function automatic int clip(input int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    function automatic exp_t model(input bit m, input int x, input int y, input int a, input int tag);
        exp_t e;
        real th;
        e.tag = tag;
        e.tol = cur_tol;
        e.atol = cur_atol;
        e.acc = cyc;
        e.lat = cur_lat;
        if (!m) begin
            th = real'(a) * PI / 32768.0;
            e.x = clip(rnd(k_gain * (real'(x) * $cos(th) - real'(y) * $sin(th))));
            e.y = clip(rnd(k_gain * (real'(x) * $sin(th) + real'(y) * $cos(th))));
            e.a = 0;
        end else begin
            e.x = clip(rnd(k_gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y))));
            e.y = 0;
            e.a = clip(rnd(real'(a) + $atan2(real'(y), real'(x)) * 32768.0 / PI));
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv, input int tol);
        checks++;
        assert (obs - expv <= tol && expv - obs <= tol) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        #1;
        acc = 1'b0;
        if (!reset) begin
            if (held) begin
                chk_eq("stall_out_x", 32'(out_x), 32'(sx));
                chk_eq("stall_out_y", 32'(out_y), 32'(sy));
                chk_eq("stall_out_angle", 32'(out_angle), 32'(sa));
                chk_eq("stall_out_tag", 32'(out_tag), 32'(st));
            end
            held = out_valid && !out_ready;
            if (held) begin
                sx = out_x; sy = out_y; sa = out_angle; st = out_tag;
                chk_eq("stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_output observed_tag=%0d expected=none", out_tag);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    n_out++;
                    chk("out_tag", int'(out_tag), e.tag, 0);
                    chk("out_x", int'($signed(out_x)), e.x, e.tol);
                    chk("out_y", int'($signed(out_y)), e.y, e.tol);
                    chk("out_angle", int'($signed(out_angle)), e.a, e.atol);
                    if (e.lat) chk("latency", cyc - e.acc, N, 0);
                end
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                q.push_back(model(in_mode, int'($signed(in_x)), int'($signed(in_y)),
                                  int'($signed(in_angle)), int'(in_tag)));
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input bit m, input int x, input int y, input int a, input int tag);
        in_mode = m; in_x = W'(x); in_y = W'(y); in_angle = W'(a); in_tag = T'(tag);
        in_valid = 1'b1;
    endtask

    task automatic send(input bit m, input int x, input int y, input int a, input int tag);
        drive(m, x, y, a, tag);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc) break;
        end
        checks++;
        assert (acc) else begin
            failures++;
            $error("FAIL accept_timeout observed=0 expected=1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && q.size() > 0; i++) tick();
        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout observed_pending=%0d expected=0", q.size());
        end
    endtask

    initial begin
        int k, base;
        for (int i = 0; i < N; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_eq("reset_out_valid", 32'(out_valid), 32'd0);
        chk_eq("reset_in_ready", 32'(in_ready), 32'd1);
        chk_eq("reset_out_x", 32'(out_x), 32'd0);
        chk_eq("reset_out_tag", 32'(out_tag), 32'd0);

        send(1'b0, 10000, 0, 0, 1);
        drain(40);
        send(1'b0, 10000, 0, 16384, 2);
        drain(40);
        send(1'b1, 10000, 10000, 0, 3);
        drain(40);
        cur_atol = 0;
        send(1'b1, 10000, 10000, 32000, 4);
        send(1'b1, 10000, -10000, -32000, 5);
        drain(40);

        for (int i = 0; i < 32; i++) begin
            md[i] = int'($urandom_range(1));
            if (md[i] == 0) begin
                rx[i] = int'($urandom_range(24000)) - 12000;
                ry[i] = int'($urandom_range(24000)) - 12000;
                ra[i] = int'($urandom_range(32768)) - 16384;
            end else begin
                rx[i] = int'($urandom_range(12000, 2000));
                ry[i] = int'($urandom_range(24000)) - 12000;
                ra[i] = int'($urandom_range(16000)) - 8000;
            end
        end
        cur_tol = 32; cur_atol = 32; cur_lat = 1'b0;
        base = n_out;
        k = 0;
        for (int c = 0; c < 300 && k < 32; c++) begin
            out_ready = !(c >= 22 && c < 27);
            drive(md[k][0], rx[k], ry[k], ra[k], k);
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(100);
        chk("stream_count", n_out - base, 32, 0);

        cur_tol = 16; cur_atol = 16; cur_lat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 3000 + i, 100, 1000, i);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        held = 1'b0;
        #1;
        chk_eq("flush_out_valid", 32'(out_valid), 32'd0);
        chk_eq("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_eq("flush_idle_valid", 32'(out_valid), 32'd0);
        end
        send(1'b0, 5000, 3000, 4000, 9);
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
